// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
// Package : rv32i_types
// Shared constants and types for the ROB commit controller.
// Revision: 1.0
// ============================================================================
package rv32i_types;

    localparam int ROB_DEPTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        ROB_RUN      = 2'd0,
        ROB_FLUSH    = 2'd1,
        ROB_REDIRECT = 2'd2
    } rob_ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/rob_wrap_ptr.sv
`default_nettype none
// ============================================================================
// Module  : rob_wrap_ptr
// Circular pointer with an extra wrap bit above the index; clear beats inc.
// Revision: 1.0
// ============================================================================
module rob_wrap_ptr #(
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [PTR_W:0]   o_ptr
);

    logic [PTR_W:0] r_ptr;

    always_ff @(posedge clk) begin
        if (!rst || i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    assign o_ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/rob_commit_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : rob_commit_ctrl
// ROB sequencer: pointers, ready bits, in-order commit and flush/redirect.
// Revision: 1.0
// ============================================================================
module rob_commit_ctrl
    import rv32i_types::*;
#(
    parameter int  ROB_DEPTH = ROB_DEPTH_DEFAULT,
    parameter int  NUM_CDB   = 2,
    localparam int PTR_W     = $clog2(ROB_DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_alloc_valid,
    output logic                       o_alloc_ready,
    output logic [PTR_W-1:0]           o_alloc_idx,
    input  logic [NUM_CDB-1:0]         i_cdb_valid,
    input  logic [NUM_CDB*PTR_W-1:0]   i_cdb_idx,
    input  logic                       i_head_mispredict,
    input  logic                       i_rrf_ready,
    input  logic                       i_fe_redirect_ack,
    output logic                       o_rob_commit,
    output logic [PTR_W-1:0]           o_rob_commit_idx,
    output logic                       o_rob_flush,
    output logic                       o_rob_empty,
    output logic                       o_rob_full,
    output logic [PTR_W:0]             o_rob_count,
    output logic [63:0]                o_commit_order
);

    rob_ctrl_state_t       r_state;
    rob_ctrl_state_t       w_state_nxt;
    logic [ROB_DEPTH-1:0]  r_ready;
    logic [ROB_DEPTH-1:0]  w_ready_nxt;
    logic [63:0]           r_commit_order;
    logic [PTR_W:0]        w_head;
    logic [PTR_W:0]        w_tail;
    logic [PTR_W:0]        w_count;
    logic [PTR_W-1:0]      w_head_idx;
    logic [PTR_W-1:0]      w_tail_idx;
    logic                  w_run;
    logic                  w_flush;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_alloc_fire;
    logic                  w_commit;
    logic [NUM_CDB-1:0]    w_cdb_hit;
    logic [PTR_W-1:0]      w_cdb_idx [NUM_CDB];

    rob_wrap_ptr #(.PTR_W(PTR_W)) u_head (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_commit),
        .i_clr (w_flush),
        .o_ptr (w_head)
    );

    rob_wrap_ptr #(.PTR_W(PTR_W)) u_tail (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_alloc_fire),
        .i_clr (w_flush),
        .o_ptr (w_tail)
    );

    assign w_head_idx   = w_head[PTR_W-1:0];
    assign w_tail_idx   = w_tail[PTR_W-1:0];
    assign w_count      = w_tail - w_head;
    assign w_empty      = (w_head == w_tail);
    assign w_full       = (w_head_idx == w_tail_idx) && (w_head[PTR_W] != w_tail[PTR_W]);
    assign w_run        = (r_state == ROB_RUN);
    assign w_flush      = (r_state == ROB_FLUSH);
    assign w_alloc_fire = i_alloc_valid && o_alloc_ready;
    assign w_commit     = w_run && !w_empty && r_ready[w_head_idx] && i_rrf_ready;

    // A completion counts only if its distance from head is below the occupancy.
    generate
        for (genvar g = 0; g < NUM_CDB; g++) begin : g_cdb
            logic [PTR_W-1:0] w_off;
            assign w_cdb_idx[g] = i_cdb_idx[g*PTR_W +: PTR_W];
            assign w_off        = w_cdb_idx[g] - w_head_idx;
            assign w_cdb_hit[g] = w_run && i_cdb_valid[g] && ({1'b0, w_off} < w_count);
        end
    endgenerate

    always_comb begin
        w_ready_nxt = r_ready;
        for (int p = 0; p < NUM_CDB; p++) begin
            if (w_cdb_hit[p]) begin
                w_ready_nxt[w_cdb_idx[p]] = 1'b1;
            end
        end
        if (w_commit) begin
            w_ready_nxt[w_head_idx] = 1'b0;
        end
        if (w_alloc_fire) begin
            w_ready_nxt[w_tail_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || w_flush) begin
            r_ready <= '0;
        end else begin
            r_ready <= w_ready_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ROB_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ROB_RUN:      if (w_commit && i_head_mispredict) w_state_nxt = ROB_FLUSH;
            ROB_FLUSH:    w_state_nxt = ROB_REDIRECT;
            ROB_REDIRECT: if (i_fe_redirect_ack) w_state_nxt = ROB_RUN;
            default:      w_state_nxt = ROB_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_commit_order <= '0;
        end else if (w_commit) begin
            r_commit_order <= r_commit_order + 64'd1;
        end
    end

    assign o_alloc_ready    = w_run && !w_full;
    assign o_alloc_idx      = w_tail_idx;
    assign o_rob_commit     = w_commit;
    assign o_rob_commit_idx = w_head_idx;
    assign o_rob_flush      = w_flush;
    assign o_rob_empty      = w_empty;
    assign o_rob_full       = w_full;
    assign o_rob_count      = w_count;
    assign o_commit_order   = r_commit_order;

endmodule
`default_nettype wire

// File: tb/tb_rob_commit_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_rob_commit_ctrl
// Self-checking bench: occupancy-level reference model plus directed scenarios.
// Revision: 1.0
// ============================================================================
module tb_rob_commit_ctrl;

    localparam int DEPTH = 16;
    localparam int NCDB  = 2;
    localparam int PW    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              alloc_valid;
    logic              alloc_ready;
    logic [PW-1:0]     alloc_idx;
    logic [NCDB-1:0]   cdb_valid;
    logic [NCDB*PW-1:0] cdb_idx;
    logic              head_mispredict;
    logic              rrf_ready;
    logic              fe_redirect_ack;
    logic              rob_commit;
    logic [PW-1:0]     rob_commit_idx;
    logic              rob_flush;
    logic              rob_empty;
    logic              rob_full;
    logic [PW:0]       rob_count;
    logic [63:0]       commit_order;

    int n_err = 0;
    int n_chk = 0;

    rob_commit_ctrl #(.ROB_DEPTH(DEPTH), .NUM_CDB(NCDB)) dut (
        .clk               (clk),
        .rst               (rst),
        .i_alloc_valid     (alloc_valid),
        .o_alloc_ready     (alloc_ready),
        .o_alloc_idx       (alloc_idx),
        .i_cdb_valid       (cdb_valid),
        .i_cdb_idx         (cdb_idx),
        .i_head_mispredict (head_mispredict),
        .i_rrf_ready       (rrf_ready),
        .i_fe_redirect_ack (fe_redirect_ack),
        .o_rob_commit      (rob_commit),
        .o_rob_commit_idx  (rob_commit_idx),
        .o_rob_flush       (rob_flush),
        .o_rob_empty       (rob_empty),
        .o_rob_full        (rob_full),
        .o_rob_count       (rob_count),
        .o_commit_order    (commit_order)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: sequence numbers grow without bound; index = seq % DEPTH.
    int          m_mode;   // 0 normal, 1 flushing, 2 waiting for frontend
    int          m_head;
    int          m_tail;
    bit [DEPTH-1:0] m_rdy;
    longint      m_order;
    bit          m_valid = 1'b0;

    always @(negedge clk) begin
        int  occ;
        int  idx;
        int  off;
        bit  e_ar;
        bit  e_commit;
        bit [DEPTH-1:0] nr;
        if (m_valid) begin
            occ      = m_tail - m_head;
            e_ar     = (m_mode == 0) && (occ < DEPTH);
            e_commit = (m_mode == 0) && (occ > 0) && m_rdy[m_head % DEPTH] && rrf_ready;
            chk("alloc_ready", alloc_ready, e_ar);
            if (alloc_valid && e_ar) chk("alloc_idx", alloc_idx, m_tail % DEPTH);
            chk("rob_commit", rob_commit, e_commit);
            if (e_commit) chk("commit_idx", rob_commit_idx, m_head % DEPTH);
            chk("rob_flush", rob_flush, m_mode == 1);
            chk("rob_empty", rob_empty, occ == 0);
            chk("rob_full", rob_full, occ == DEPTH);
            chk("rob_count", rob_count, occ);
            chk("commit_order", commit_order, m_order);
            if (rst) begin
                if (m_mode == 0) begin
                    nr = m_rdy;
                    for (int p = 0; p < NCDB; p++) begin
                        if (cdb_valid[p]) begin
                            idx = int'(cdb_idx[p*PW +: PW]);
                            off = (idx - (m_head % DEPTH) + DEPTH) % DEPTH;
                            if (off < occ) nr[idx] = 1'b1;
                        end
                    end
                    if (e_commit) begin
                        nr[m_head % DEPTH] = 1'b0;
                        m_head++;
                        m_order++;
                        if (head_mispredict) m_mode = 1;
                    end
                    if (alloc_valid && e_ar) begin
                        nr[m_tail % DEPTH] = 1'b0;
                        m_tail++;
                    end
                    m_rdy = nr;
                end else if (m_mode == 1) begin
                    m_head = 0;
                    m_tail = 0;
                    m_rdy  = '0;
                    m_mode = 2;
                end else if (fe_redirect_ack) begin
                    m_mode = 0;
                end
            end
        end
        if (!rst) begin
            m_mode  = 0;
            m_head  = 0;
            m_tail  = 0;
            m_rdy   = '0;
            m_order = 0;
            m_valid = 1'b1;
        end
    end

    int bidx;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid     = 1'b0;
        cdb_valid       = '0;
        cdb_idx         = '0;
        head_mispredict = 1'b0;
        rrf_ready       = 1'b0;
        fe_redirect_ack = 1'b0;
        rst             = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        tick();
        rst  = 1'b1;
        bidx = 0;
    endtask

    // Allocate, complete, then retire one entry.
    task automatic one_commit(input bit mis);
        alloc_valid = 1'b1;
        tick();
        alloc_valid  = 1'b0;
        cdb_valid[0] = 1'b1;
        cdb_idx[PW-1:0] = PW'(bidx);
        tick();
        cdb_valid       = '0;
        rrf_ready       = 1'b1;
        head_mispredict = mis;
        #1;
        chk("one_commit", rob_commit, 1'b1);
        tick();
        rrf_ready       = 1'b0;
        head_mispredict = 1'b0;
        bidx            = (bidx + 1) % DEPTH;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rst_empty", rob_empty, 1'b1);
        chk("rst_count", rob_count, 0);
        chk("rst_ready", alloc_ready, 1'b1);
        chk("rst_order", commit_order, 0);

        // Fill to full, then drain.
        for (int i = 0; i < DEPTH; i++) begin
            alloc_valid = 1'b1;
            #1;
            chk("fill_idx", alloc_idx, i);
            tick();
        end
        alloc_valid = 1'b0;
        #1;
        chk("full_flag", rob_full, 1'b1);
        chk("full_ready", alloc_ready, 1'b0);
        chk("full_count", rob_count, 16);
        for (int i = 0; i < DEPTH / 2; i++) begin
            cdb_valid = 2'b11;
            cdb_idx   = {PW'(2*i+1), PW'(2*i)};
            tick();
        end
        cdb_valid = '0;
        rrf_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) tick();
        rrf_ready = 1'b0;
        #1;
        chk("drain_empty", rob_empty, 1'b1);
        chk("drain_order", commit_order, 16);

        // Out-of-order completion, in-order retirement.
        do_reset();
        alloc_valid = 1'b1;
        #1;
        chk("ooo_idx0", alloc_idx, 0);
        tick();
        #1;
        chk("ooo_idx1", alloc_idx, 1);
        tick();
        alloc_valid  = 1'b0;
        rrf_ready    = 1'b1;
        cdb_valid[0] = 1'b1;
        cdb_idx[PW-1:0] = 4'd1;
        #1;
        chk("ooo_T", rob_commit, 1'b0);
        tick();
        cdb_idx[PW-1:0] = 4'd0;
        #1;
        chk("ooo_T1", rob_commit, 1'b0);
        tick();
        cdb_valid = '0;
        #1;
        chk("ooo_T2_c", rob_commit, 1'b1);
        chk("ooo_T2_i", rob_commit_idx, 0);
        chk("ooo_T2_o", commit_order, 0);
        tick();
        chk("ooo_T3_c", rob_commit, 1'b1);
        chk("ooo_T3_i", rob_commit_idx, 1);
        chk("ooo_T3_o", commit_order, 1);
        tick();
        chk("ooo_end_e", rob_empty, 1'b1);
        chk("ooo_end_o", commit_order, 2);
        rrf_ready = 1'b0;

        // Alloc and commit together across the wrap point.
        do_reset();
        for (int i = 0; i < 12; i++) one_commit(1'b0);
        for (int i = 0; i < 8; i++) begin
            alloc_valid = 1'b1;
            tick();
        end
        alloc_valid  = 1'b0;
        cdb_valid[0] = 1'b1;
        cdb_idx[PW-1:0] = 4'd12;
        tick();
        cdb_valid   = '0;
        alloc_valid = 1'b1;
        rrf_ready   = 1'b1;
        #1;
        chk("wrap_commit", rob_commit, 1'b1);
        chk("wrap_cidx", rob_commit_idx, 12);
        chk("wrap_aidx", alloc_idx, 4);
        chk("wrap_cnt0", rob_count, 8);
        tick();
        alloc_valid = 1'b0;
        rrf_ready   = 1'b0;
        #1;
        chk("wrap_cnt1", rob_count, 8);
        chk("wrap_aidx1", alloc_idx, 5);
        chk("wrap_head1", rob_commit_idx, 13);

        // Mispredicted branch at head with three younger entries.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            alloc_valid = 1'b1;
            tick();
        end
        alloc_valid  = 1'b0;
        cdb_valid[0] = 1'b1;
        cdb_idx[PW-1:0] = 4'd0;
        tick();
        cdb_valid       = '0;
        head_mispredict = 1'b1;
        rrf_ready       = 1'b1;
        #1;
        chk("mis_commit", rob_commit, 1'b1);
        tick();
        head_mispredict = 1'b0;
        rrf_ready       = 1'b0;
        alloc_valid     = 1'b1;
        cdb_valid[0]    = 1'b1;
        cdb_idx[PW-1:0] = 4'd1;
        #1;
        chk("mis_flush", rob_flush, 1'b1);
        chk("mis_fl_ar", alloc_ready, 1'b0);
        tick();
        chk("mis_flush_off", rob_flush, 1'b0);
        chk("mis_cnt", rob_count, 0);
        chk("mis_rd_ar", alloc_ready, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        fe_redirect_ack = 1'b1;
        #1;
        chk("mis_ack_ar", alloc_ready, 1'b0);
        tick();
        fe_redirect_ack = 1'b0;
        alloc_valid     = 1'b0;
        cdb_valid       = '0;
        #1;
        chk("mis_run_ar", alloc_ready, 1'b1);
        chk("mis_run_idx", alloc_idx, 0);
        chk("mis_order", commit_order, 1);

        // Completion to an unoccupied slot must not leak.
        bidx = 0;
        one_commit(1'b0);
        one_commit(1'b0);
        cdb_valid[0] = 1'b1;
        cdb_idx[PW-1:0] = 4'd5;
        tick();
        cdb_valid = '0;
        for (int i = 0; i < 4; i++) begin
            alloc_valid = 1'b1;
            tick();
        end
        alloc_valid = 1'b0;
        rrf_ready   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ghost_commit", rob_commit, 1'b0);
            tick();
        end
        rrf_ready = 1'b0;

        // Reset while waiting for the frontend.
        do_reset();
        for (int i = 0; i < 36; i++) one_commit(1'b0);
        one_commit(1'b1);
        tick();
        tick();
        #1;
        chk("rd_order", commit_order, 37);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("rr_order", commit_order, 0);
        chk("rr_empty", rob_empty, 1'b1);
        chk("rr_ready", alloc_ready, 1'b1);

        // Randomized traffic, checked against the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            rst             = ($urandom_range(0, 499) != 0);
            alloc_valid     = ($urandom_range(0, 2) != 0);
            cdb_valid       = 2'($urandom);
            cdb_idx         = 8'($urandom);
            rrf_ready       = ($urandom_range(0, 3) != 0);
            head_mispredict = ($urandom_range(0, 29) == 0);
            fe_redirect_ack = ($urandom_range(0, 3) == 0);
            tick();
        end
        idle();
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
